dram_req_arbiter: RTL and testbench



---
 rtl/dram_req_arbiter_pkg.sv | 47 ++++
 rtl/dram_req_arbiter.sv | 204 ++++++++++++++++++++
 tb/tb_dram_req_arbiter.sv | 370 +++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/dram_req_arbiter_pkg.sv
// Shared types, defaults and helpers for the DRAM request arbiter.
package dram_req_arbiter_pkg;

  // Arbiter states
  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_WR_D = 3'd1,
    ST_RD_D = 3'd2,
    ST_RD_I = 3'd3,
    ST_GAP  = 3'd4
  } state_t;

  // Requesting source; declaration order mirrors grant priority (highest first)
  typedef enum logic [1:0] {
    SRC_NONE  = 2'd0,
    SRC_DC_WR = 2'd1,
    SRC_DC_RD = 2'd2,
    SRC_IC_RD = 2'd3
  } src_t;

  localparam int BLOCK_SIZE_I_DEF = 16;
  localparam int BLOCK_SIZE_D_DEF = 8;

  // Idle cycles inserted after a read block so the controller can finish its return cycles
  localparam int GAP_CYCLES = 2;

  // Fixed-priority pick: D writeback beats D refill beats I refill
  function automatic src_t pick_source(input logic dc_wr, input logic dc_rd, input logic ic_rd);
    src_t src;
    if (dc_wr) begin
      src = SRC_DC_WR;
    end else if (dc_rd) begin
      src = SRC_DC_RD;
    end else if (ic_rd) begin
      src = SRC_IC_RD;
    end else begin
      src = SRC_NONE;
    end
    return src;
  endfunction

  // Clear the low lg address bits so the address points at the start of its block
  function automatic logic [31:0] block_align(input logic [31:0] addr, input int unsigned lg);
    return addr & ~((32'h1 << lg) - 32'h1);
  endfunction

endpackage

// File: rtl/dram_req_arbiter.sv
// Cache-side initiator for the DRAM controller: arbitrates I refill, D refill and
// D writeback, runs one block transaction at a time, steers returned words back to
// the requesting cache and enforces the post-read gap the controller needs.
module dram_req_arbiter
  import dram_req_arbiter_pkg::*;
#(
  parameter int BLOCK_SIZE_I = BLOCK_SIZE_I_DEF,
  parameter int BLOCK_SIZE_D = BLOCK_SIZE_D_DEF
) (
  input  logic        clock,
  input  logic        rst,
  input  logic        ic_rd_req,
  input  logic [31:0] ic_rd_addr,
  input  logic        dc_rd_req,
  input  logic [31:0] dc_rd_addr,
  input  logic        dc_wr_req,
  input  logic [31:0] dc_wr_addr,
  input  logic [31:0] dc_wr_data,
  output logic [2:0]  dc_wr_idx,
  output logic        ic_rd_val,
  output logic        dc_rd_val,
  output logic [3:0]  ic_rd_idx,
  output logic [2:0]  dc_rd_idx,
  output logic [31:0] ic_rd_data,
  output logic [31:0] dc_rd_data,
  output logic        ic_done,
  output logic        dc_done,
  output logic        dram_wr_req,
  output logic        dram_rd_req,
  output logic        idrd_req,
  output logic [31:0] dram_wr_addr,
  output logic [31:0] dram_rd_addr,
  output logic [31:0] dram_wr_data,
  input  logic        dram_wr_val,
  input  logic        dram_rd_val,
  input  logic [31:0] dram_rd_data
);

  localparam int unsigned LG_I   = $clog2(BLOCK_SIZE_I);
  localparam int unsigned LG_D   = $clog2(BLOCK_SIZE_D);
  localparam logic [3:0]  LAST_I = 4'(BLOCK_SIZE_I - 1);
  localparam logic [3:0]  LAST_D = 4'(BLOCK_SIZE_D - 1);
  localparam logic        GAP_END = 1'(GAP_CYCLES - 1);

  state_t      state, state_nxt;
  logic [3:0]  wcnt;
  logic [31:0] addr;
  logic        gap_cnt;
  logic        rd_req_q;
  logic        idrd_q;
  logic        ic_done_q;
  logic        dc_done_q;

  src_t        src;
  logic [31:0] grant_addr;
  logic        wr_last;
  logic        rd_last_d;
  logic        rd_last_i;

  // Last-strobe detection for each active transaction type
  always_comb begin
    wr_last   = (state == ST_WR_D) & dram_wr_val & (wcnt == LAST_D);
    rd_last_d = (state == ST_RD_D) & dram_rd_val & (wcnt == LAST_D);
    rd_last_i = (state == ST_RD_I) & dram_rd_val & (wcnt == LAST_I);
  end

  // Winning source and its block-aligned address for the IDLE grant
  always_comb begin
    src        = pick_source(dc_wr_req, dc_rd_req, ic_rd_req);
    grant_addr = 32'h0;
    case (src)
      SRC_DC_WR: grant_addr = block_align(dc_wr_addr, LG_D);
      SRC_DC_RD: grant_addr = block_align(dc_rd_addr, LG_D);
      SRC_IC_RD: grant_addr = block_align(ic_rd_addr, LG_I);
      default:   grant_addr = 32'h0;
    endcase
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: begin
        case (src)
          SRC_DC_WR: state_nxt = ST_WR_D;
          SRC_DC_RD: state_nxt = ST_RD_D;
          SRC_IC_RD: state_nxt = ST_RD_I;
          default:   state_nxt = ST_IDLE;
        endcase
      end
      ST_WR_D: begin
        if (wr_last) begin
          state_nxt = ST_IDLE;
        end else begin
          state_nxt = ST_WR_D;
        end
      end
      ST_RD_D: begin
        if (rd_last_d) begin
          state_nxt = ST_GAP;
        end else begin
          state_nxt = ST_RD_D;
        end
      end
      ST_RD_I: begin
        if (rd_last_i) begin
          state_nxt = ST_GAP;
        end else begin
          state_nxt = ST_RD_I;
        end
      end
      ST_GAP: begin
        if (gap_cnt == GAP_END) begin
          state_nxt = ST_IDLE;
        end else begin
          state_nxt = ST_GAP;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clock or posedge rst) begin
    if (rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Word counter: cleared while idle (so every grant starts at 0), counts matching strobes only
  always_ff @(posedge clock or posedge rst) begin
    if (rst) begin
      wcnt <= 4'd0;
    end else if (state == ST_IDLE) begin
      wcnt <= 4'd0;
    end else if ((state == ST_WR_D) && dram_wr_val) begin
      wcnt <= wcnt + 4'd1;
    end else if (((state == ST_RD_D) || (state == ST_RD_I)) && dram_rd_val) begin
      wcnt <= wcnt + 4'd1;
    end else begin
      wcnt <= wcnt;
    end
  end

  // Block address: captured on grant and held for the whole transaction
  always_ff @(posedge clock or posedge rst) begin
    if (rst) begin
      addr <= 32'h0;
    end else if ((state == ST_IDLE) && (src != SRC_NONE)) begin
      addr <= grant_addr;
    end else begin
      addr <= addr;
    end
  end

  // Gap cycle counter
  always_ff @(posedge clock or posedge rst) begin
    if (rst) begin
      gap_cnt <= 1'b0;
    end else if (state == ST_GAP) begin
      gap_cnt <= gap_cnt + 1'b1;
    end else begin
      gap_cnt <= 1'b0;
    end
  end

  // Registered read request, block-size select and done pulses
  always_ff @(posedge clock or posedge rst) begin
    if (rst) begin
      rd_req_q  <= 1'b0;
      idrd_q    <= 1'b0;
      ic_done_q <= 1'b0;
      dc_done_q <= 1'b0;
    end else begin
      rd_req_q  <= (state_nxt == ST_RD_D) || (state_nxt == ST_RD_I);
      idrd_q    <= (state_nxt == ST_RD_I);
      ic_done_q <= rd_last_i;
      dc_done_q <= wr_last | rd_last_d;
    end
  end

  // Output steering; the write request drops in the last-strobe cycle because the
  // controller is already idle then and would otherwise see a new request
  always_comb begin
    dram_rd_req  = rd_req_q;
    idrd_req     = idrd_q;
    ic_done      = ic_done_q;
    dc_done      = dc_done_q;
    dram_wr_addr = addr;
    dram_rd_addr = addr;
    dram_wr_req  = (state == ST_WR_D) & ~wr_last;
    dram_wr_data = (state == ST_WR_D) ? dc_wr_data : 32'h0;
    dc_wr_idx    = (state == ST_WR_D) ? wcnt[2:0] : 3'd0;
    ic_rd_val    = dram_rd_val & (state == ST_RD_I);
    ic_rd_idx    = (state == ST_RD_I) ? wcnt : 4'd0;
    ic_rd_data   = (state == ST_RD_I) ? dram_rd_data : 32'h0;
    dc_rd_val    = dram_rd_val & (state == ST_RD_D);
    dc_rd_idx    = (state == ST_RD_D) ? wcnt[2:0] : 3'd0;
    dc_rd_data   = (state == ST_RD_D) ? dram_rd_data : 32'h0;
  end

endmodule

// File: tb/tb_dram_req_arbiter.sv
// Directed testbench for dram_req_arbiter with a small DRAM controller model.
module tb_dram_req_arbiter;

  logic        clock = 1'b0;
  logic        rst = 1'b0;
  logic        ic_rd_req = 1'b0, dc_rd_req = 1'b0, dc_wr_req = 1'b0;
  logic [31:0] ic_rd_addr = 32'h0, dc_rd_addr = 32'h0, dc_wr_addr = 32'h0;
  logic [31:0] dc_wr_data;
  logic [2:0]  dc_wr_idx;
  logic        ic_rd_val, dc_rd_val;
  logic [3:0]  ic_rd_idx;
  logic [2:0]  dc_rd_idx;
  logic [31:0] ic_rd_data, dc_rd_data;
  logic        ic_done, dc_done;
  logic        dram_wr_req, dram_rd_req, idrd_req;
  logic [31:0] dram_wr_addr, dram_rd_addr, dram_wr_data;
  logic        dram_wr_val, dram_rd_val;
  logic [31:0] dram_rd_data;

  logic        model_en = 1'b1;
  logic        f_rd_val = 1'b0, f_wr_val = 1'b0;
  logic [31:0] f_rd_data = 32'h0;
  logic        m_rd_val, m_wr_val;
  logic [31:0] m_rd_data;
  int          m_phase, m_cnt, m_words, m_busy, m_spurious;
  logic [31:0] m_addr;

  int checks = 0;
  int errors = 0;

  always #5 clock = ~clock;

  assign dc_wr_data   = 32'hD000_0000 | {29'h0, dc_wr_idx};
  assign dram_rd_val  = model_en ? m_rd_val  : f_rd_val;
  assign dram_wr_val  = model_en ? m_wr_val  : f_wr_val;
  assign dram_rd_data = model_en ? m_rd_data : f_rd_data;

  dram_req_arbiter dut (
    .clock(clock), .rst(rst),
    .ic_rd_req(ic_rd_req), .ic_rd_addr(ic_rd_addr),
    .dc_rd_req(dc_rd_req), .dc_rd_addr(dc_rd_addr),
    .dc_wr_req(dc_wr_req), .dc_wr_addr(dc_wr_addr),
    .dc_wr_data(dc_wr_data), .dc_wr_idx(dc_wr_idx),
    .ic_rd_val(ic_rd_val), .dc_rd_val(dc_rd_val),
    .ic_rd_idx(ic_rd_idx), .dc_rd_idx(dc_rd_idx),
    .ic_rd_data(ic_rd_data), .dc_rd_data(dc_rd_data),
    .ic_done(ic_done), .dc_done(dc_done),
    .dram_wr_req(dram_wr_req), .dram_rd_req(dram_rd_req), .idrd_req(idrd_req),
    .dram_wr_addr(dram_wr_addr), .dram_rd_addr(dram_rd_addr), .dram_wr_data(dram_wr_data),
    .dram_wr_val(dram_wr_val), .dram_rd_val(dram_rd_val), .dram_rd_data(dram_rd_data)
  );

  // Read word pattern returned by the controller model
  function automatic logic [31:0] rd_word(input logic [31:0] a, input int i);
    return (a + 32'(i)) ^ 32'hA5A5_0000;
  endfunction

  // Controller model: 2-cycle start latency, one word per cycle, 3 busy return cycles after reads
  initial begin : ctrl_model
    m_phase = 0; m_cnt = 0; m_words = 0; m_busy = 0; m_spurious = 0; m_addr = 32'h0;
    m_rd_val = 1'b0; m_wr_val = 1'b0; m_rd_data = 32'h0;
    forever begin
      @(posedge clock); #1;
      m_rd_val = 1'b0; m_wr_val = 1'b0;
      if (rst || !model_en) begin
        m_phase = 0;
      end else begin
        case (m_phase)
          0: if (dram_rd_req) begin
               m_phase = 1; m_cnt = 0; m_words = idrd_req ? 16 : 8;
             end else if (dram_wr_req) begin
               m_phase = 3; m_cnt = 0;
             end
          1: begin m_addr = dram_rd_addr; m_phase = 2; end
          2: begin
               m_rd_val = 1'b1; m_rd_data = rd_word(m_addr, m_cnt); m_cnt++;
               if (m_cnt == m_words) begin m_phase = 4; m_busy = 3; end
             end
          3: m_phase = 5;
          4: begin
               if (dram_rd_req || dram_wr_req) m_spurious++;
               m_busy--;
               if (m_busy == 0) m_phase = 0;
             end
          5: begin
               m_wr_val = 1'b1; m_cnt++;
               if (m_cnt == 8) m_phase = 0;
             end
          default: m_phase = 0;
        endcase
      end
    end
  end

  task automatic step();
    @(posedge clock); #2;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    #3;
    checks++;
    if ({dram_wr_req, dram_rd_req, idrd_req, dram_wr_addr, dram_rd_addr, dram_wr_data,
         ic_rd_val, dc_rd_val, ic_rd_idx, dc_rd_idx, ic_rd_data, dc_rd_data,
         ic_done, dc_done, dc_wr_idx} !== '0) begin
      errors++; $display("FAIL reset_outputs: some output nonzero during reset, want all 0");
    end
    repeat (2) step();
    rst = 1'b0;
    repeat (2) step();
    checks++;
    if ({dram_rd_req, dram_wr_req} !== 2'b00) begin
      errors++; $display("FAIL reset_idle_req got %b want 00", {dram_rd_req, dram_wr_req});
    end
  endtask

  task automatic test_dc_write();
    int k = 0, done_n = 0, after = -1;
    bit seen = 0;
    repeat (2) step();
    dc_wr_addr = 32'h0000_0013; dc_wr_req = 1'b1;
    for (int c = 0; c < 80 && after != 0; c++) begin
      step();
      if (after > 0) after--;
      if (dram_wr_req && !seen) begin
        seen = 1; checks++;
        if (dram_wr_addr !== 32'h10) begin
          errors++; $display("FAIL wr_addr got %h want %h", dram_wr_addr, 32'h10);
        end
      end
      if (dram_wr_val) begin
        checks++;
        if (dc_wr_idx !== k[2:0]) begin
          errors++; $display("FAIL wr_idx got %0d want %0d", dc_wr_idx, k);
        end
        checks++;
        if (dram_wr_data !== (32'hD000_0000 | 32'(k))) begin
          errors++; $display("FAIL wr_data got %h want %h", dram_wr_data, 32'hD000_0000 | 32'(k));
        end
        checks++;
        if (dram_wr_req !== ((k == 7) ? 1'b0 : 1'b1)) begin
          errors++; $display("FAIL wr_req_at_strobe %0d got %b", k, dram_wr_req);
        end
        k++;
      end
      if (dc_done) begin
        done_n++; dc_wr_req = 1'b0;
        if (after < 0) after = 3;
      end
    end
    checks++;
    if (k != 8) begin errors++; $display("FAIL wr_word_count got %0d want 8", k); end
    checks++;
    if (done_n != 1) begin errors++; $display("FAIL wr_done_pulses got %0d want 1", done_n); end
    dc_wr_req = 1'b0;
  endtask

  task automatic test_ic_refill();
    int k = 0, done_n = 0, after = -1, bad_dc = 0;
    bit seen = 0;
    repeat (3) step();
    ic_rd_addr = 32'h45; ic_rd_req = 1'b1;
    for (int c = 0; c < 120 && after != 0; c++) begin
      step();
      if (after > 0) after--;
      if (dram_rd_req && !seen) begin
        seen = 1; checks++;
        if ({idrd_req, dram_rd_addr} !== {1'b1, 32'h40}) begin
          errors++; $display("FAIL ic_req_addr got idrd=%b addr=%h want 1/%h", idrd_req, dram_rd_addr, 32'h40);
        end
      end
      if (dc_rd_val) bad_dc++;
      if (ic_rd_val) begin
        checks++;
        if (ic_rd_idx !== k[3:0]) begin
          errors++; $display("FAIL ic_idx got %0d want %0d", ic_rd_idx, k);
        end
        checks++;
        if (ic_rd_data !== rd_word(32'h40, k)) begin
          errors++; $display("FAIL ic_data got %h want %h", ic_rd_data, rd_word(32'h40, k));
        end
        k++;
      end
      if (ic_done) begin
        done_n++; ic_rd_req = 1'b0;
        if (after < 0) after = 4;
      end
    end
    checks++;
    if (k != 16) begin errors++; $display("FAIL ic_word_count got %0d want 16", k); end
    checks++;
    if (done_n != 1) begin errors++; $display("FAIL ic_done_pulses got %0d want 1", done_n); end
    checks++;
    if (bad_dc != 0) begin errors++; $display("FAIL ic_dc_leak got %0d dc strobes want 0", bad_dc); end
    ic_rd_req = 1'b0;
  endtask

  task automatic test_priority();
    int order[3];
    int n = 0, last = -100, s0;
    bit fin = 0, prev_wr = 0, prev_rd = 0;
    order[0] = 0; order[1] = 0; order[2] = 0;
    s0 = m_spurious;
    repeat (4) step();
    dc_wr_addr = 32'h100; dc_rd_addr = 32'h20B; ic_rd_addr = 32'h3F5;
    dc_wr_req = 1'b1; dc_rd_req = 1'b1; ic_rd_req = 1'b1;
    for (int c = 0; c < 300 && !fin; c++) begin
      step();
      if (dram_wr_req && !prev_wr) begin
        if (n < 3) order[n] = 1;
        n++;
      end
      if (dram_rd_req && !prev_rd) begin
        if (n < 3) order[n] = idrd_req ? 3 : 2;
        n++;
        if (last >= 0) begin
          checks++;
          if (c - last < 4) begin
            errors++; $display("FAIL prio_gap got %0d cycles want >= 4", c - last);
          end
        end
      end
      if (ic_rd_val || dc_rd_val) last = c;
      if (dc_done) begin
        if (dc_wr_req) dc_wr_req = 1'b0;
        else dc_rd_req = 1'b0;
      end
      if (ic_done) begin ic_rd_req = 1'b0; fin = 1; end
      prev_wr = dram_wr_req; prev_rd = dram_rd_req;
    end
    checks++;
    if ({order[0], order[1], order[2]} !== {32'd1, 32'd2, 32'd3}) begin
      errors++; $display("FAIL prio_order got %0d,%0d,%0d want 1,2,3", order[0], order[1], order[2]);
    end
    checks++;
    if (n != 3) begin errors++; $display("FAIL prio_txn_count got %0d want 3", n); end
    checks++;
    if (!fin) begin errors++; $display("FAIL prio_timeout got no ic_done want done"); end
    checks++;
    if (m_spurious != s0) begin errors++; $display("FAIL prio_spurious got %0d want %0d", m_spurious, s0); end
    dc_wr_req = 1'b0; dc_rd_req = 1'b0; ic_rd_req = 1'b0;
  endtask

  task automatic test_back_to_back();
    int kd = 0, ki = 0, last = -100, s0;
    bit fin = 0, prev_rd = 0;
    s0 = m_spurious;
    repeat (4) step();
    dc_rd_addr = 32'h5C; dc_rd_req = 1'b1;
    for (int c = 0; c < 300 && !fin; c++) begin
      step();
      if (dram_rd_req && !prev_rd && last >= 0) begin
        checks++;
        if (c - last < 4) begin
          errors++; $display("FAIL b2b_gap got %0d cycles want >= 4", c - last);
        end
      end
      if (dc_rd_val) begin
        checks++;
        if ({dc_rd_idx, dc_rd_data} !== {kd[2:0], rd_word(32'h58, kd)}) begin
          errors++; $display("FAIL b2b_dc_word got idx %0d data %h want %0d %h", dc_rd_idx, dc_rd_data, kd, rd_word(32'h58, kd));
        end
        kd++; last = c;
      end
      if (ic_rd_val) begin
        checks++;
        if ({ic_rd_idx, ic_rd_data} !== {ki[3:0], rd_word(32'h1230, ki)}) begin
          errors++; $display("FAIL b2b_ic_word got idx %0d data %h want %0d %h", ic_rd_idx, ic_rd_data, ki, rd_word(32'h1230, ki));
        end
        ki++; last = c;
      end
      if (dc_done) begin
        dc_rd_req = 1'b0; ic_rd_addr = 32'h1234; ic_rd_req = 1'b1;
      end
      if (ic_done) begin ic_rd_req = 1'b0; fin = 1; end
      prev_rd = dram_rd_req;
    end
    checks++;
    if (kd != 8) begin errors++; $display("FAIL b2b_dc_count got %0d want 8", kd); end
    checks++;
    if (ki != 16) begin errors++; $display("FAIL b2b_ic_count got %0d want 16", ki); end
    repeat (4) step();
    checks++;
    if (m_spurious != s0) begin errors++; $display("FAIL b2b_spurious got %0d want %0d", m_spurious, s0); end
    dc_rd_req = 1'b0; ic_rd_req = 1'b0;
  endtask

  task automatic test_stray();
    repeat (4) step();
    model_en = 1'b0;
    f_rd_val = 1'b1; f_rd_data = 32'hDEAD_BEEF;
    #1;
    checks++;
    if ({ic_rd_val, dc_rd_val, ic_rd_data} !== {1'b0, 1'b0, 32'h0}) begin
      errors++; $display("FAIL stray_rd_strobe got ic=%b dc=%b data=%h want 0 0 0", ic_rd_val, dc_rd_val, ic_rd_data);
    end
    step();
    f_rd_val = 1'b0; f_wr_val = 1'b1;
    checks++;
    if (dut.wcnt !== 4'd0) begin errors++; $display("FAIL stray_rd_wcnt got %0d want 0", dut.wcnt); end
    step();
    f_wr_val = 1'b0;
    checks++;
    if ({dut.wcnt, dc_wr_idx, dram_wr_req} !== {4'd0, 3'd0, 1'b0}) begin
      errors++; $display("FAIL stray_wr got wcnt=%0d idx=%0d req=%b want 0 0 0", dut.wcnt, dc_wr_idx, dram_wr_req);
    end
    model_en = 1'b1;
  endtask

  task automatic test_reset_mid();
    int k = 0, done_n = 0, after = -1;
    repeat (4) step();
    ic_rd_addr = 32'h80; ic_rd_req = 1'b1;
    for (int c = 0; c < 60 && k < 3; c++) begin
      step();
      if (ic_rd_val) k++;
    end
    checks++;
    if (k != 3) begin errors++; $display("FAIL rstmid_setup got %0d words want 3", k); end
    step();
    #1 rst = 1'b1;
    #1;
    checks++;
    if ({dram_wr_req, dram_rd_req, idrd_req, dram_wr_addr, dram_rd_addr, dram_wr_data,
         ic_rd_val, dc_rd_val, ic_rd_idx, dc_rd_idx, ic_rd_data, dc_rd_data,
         ic_done, dc_done, dc_wr_idx} !== '0) begin
      errors++; $display("FAIL rstmid_outputs: some output nonzero right after async reset, want all 0");
    end
    ic_rd_req = 1'b0;
    repeat (2) step();
    rst = 1'b0;
    repeat (2) step();
    k = 0;
    dc_rd_addr = 32'h2A; dc_rd_req = 1'b1;
    for (int c = 0; c < 80 && after != 0; c++) begin
      step();
      if (after > 0) after--;
      if (dc_rd_val) begin
        checks++;
        if ({dc_rd_idx, dc_rd_data} !== {k[2:0], rd_word(32'h28, k)}) begin
          errors++; $display("FAIL rstmid_word got idx %0d data %h want %0d %h", dc_rd_idx, dc_rd_data, k, rd_word(32'h28, k));
        end
        k++;
      end
      if (dc_done) begin
        done_n++; dc_rd_req = 1'b0;
        if (after < 0) after = 4;
      end
    end
    checks++;
    if (k != 8) begin errors++; $display("FAIL rstmid_count got %0d want 8", k); end
    checks++;
    if (done_n != 1) begin errors++; $display("FAIL rstmid_done got %0d want 1", done_n); end
    dc_rd_req = 1'b0;
  endtask

  initial begin
    #1;
    test_reset();
    test_dc_write();
    test_ic_refill();
    test_priority();
    test_back_to_back();
    test_stray();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
